// File: rtl/div_arbiter_if.sv
// div_arbiter_if: bundles the two request channels, the tagged response channel
// and the divider control/result bus shared between div_arbiter and its users.
//   req0_* / req1_*     : valid/ready request channels (subtype, dividend, divisor)
//   resp_*              : valid/ready response channel tagged with requester id
//   div_*               : start/stall/flush control and operands to the divider,
//                         busy flag and result back from it
// Modports:
//   slave  : the arbiter side (consumes requests, produces responses, drives divider)
//   master : the environment side (issue pipes, consumer, divider)
interface div_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [4:0]       req0_subtype;
  logic [WIDTH-1:0] req0_din1;
  logic [WIDTH-1:0] req0_din2;

  logic             req1_valid;
  logic             req1_ready;
  logic [4:0]       req1_subtype;
  logic [WIDTH-1:0] req1_din1;
  logic [WIDTH-1:0] req1_din2;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_dout;

  logic [3:0]       div_type;
  logic [4:0]       div_subtype;
  logic [WIDTH-1:0] div_din1;
  logic [WIDTH-1:0] div_din2;
  logic             div_stall;
  logic             div_flush;
  logic             div_busy;
  logic [WIDTH-1:0] div_dout;

  modport slave (
    input  req0_valid, req0_subtype, req0_din1, req0_din2,
    output req0_ready,
    input  req1_valid, req1_subtype, req1_din1, req1_din2,
    output req1_ready,
    output resp_valid, resp_id, resp_dout,
    input  resp_ready,
    output div_type, div_subtype, div_din1, div_din2, div_stall, div_flush,
    input  div_busy, div_dout
  );

  modport master (
    output req0_valid, req0_subtype, req0_din1, req0_din2,
    input  req0_ready,
    output req1_valid, req1_subtype, req1_din1, req1_din2,
    input  req1_ready,
    input  resp_valid, resp_id, resp_dout,
    output resp_ready,
    input  div_type, div_subtype, div_din1, div_din2, div_stall, div_flush,
    output div_busy, div_dout
  );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative divider between two issue pipes.
// Round-robin arbitration between req0 and req1, operand latching, sequencing
// of the divider start (ISSUE), stall (WAIT) and drain (first RESP cycle), and a
// single tagged valid/ready response channel. Divide-by-zero and
// |dividend| < |divisor| cases are answered locally without the divider.
// Ports:
//   clk_i   : clock
//   rstn_i  : synchronous active-low reset
//   flush_i : kills any in-flight operation; no result is delivered
//   bus     : div_arbiter_if.slave (requests, response, divider control)
// Subtypes: 0=DIVW, 1=MODW, 2=DIVWU, 3=MODWU; anything else behaves as DIVWU.
module div_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter logic [3:0]  TDIV  = 4'd2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         flush_i,
  div_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state_q;
  logic             rr_q;
  logic             id_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_dout_q;
  logic [3:0]       div_type_q;
  logic [4:0]       div_subtype_q;
  logic [WIDTH-1:0] div_din1_q;
  logic [WIDTH-1:0] div_din2_q;
  logic             div_stall_q;
  logic             div_flush_q;

  logic             grant_any_s;
  logic             grant_id_s;
  logic             accept_s;
  logic [4:0]       sel_sub_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic             sel_signed_s;
  logic             sel_mod_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic             bypass_s;
  logic [WIDTH-1:0] bypass_res_s;

  // Unknown subtypes collapse onto DIVWU so the divider only ever sees 0..3.
  function automatic logic [4:0] norm_subtype_f(input logic [4:0] sub);
    logic [4:0] res;
    case (sub)
      5'd0, 5'd1, 5'd2, 5'd3: res = sub;
      default:                res = 5'd2;
    endcase
    return res;
  endfunction

  // Two's-complement magnitude for signed operations, raw value otherwise.
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] val, input logic sgn);
    logic [WIDTH-1:0] res;
    if (sgn && val[WIDTH-1]) begin
      res = (~val) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Arbitration: a sole valid requester wins; with both valid the rr pointer decides.
  always_comb begin
    grant_any_s = 1'b0;
    grant_id_s  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_any_s = 1'b1;
      grant_id_s  = rr_q;
    end else if (bus.req0_valid) begin
      grant_any_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (bus.req1_valid) begin
      grant_any_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_any_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // Operand selection and bypass decision. Evaluated on exactly the operands that
  // get latched on the accept edge, so a bypass result is registered in that same edge.
  always_comb begin
    sel_sub_s = 5'd0;
    sel_a_s   = '0;
    sel_b_s   = '0;
    if (grant_id_s) begin
      sel_sub_s = norm_subtype_f(bus.req1_subtype);
      sel_a_s   = bus.req1_din1;
      sel_b_s   = bus.req1_din2;
    end else begin
      sel_sub_s = norm_subtype_f(bus.req0_subtype);
      sel_a_s   = bus.req0_din1;
      sel_b_s   = bus.req0_din2;
    end
    sel_signed_s = (sel_sub_s == 5'd0) || (sel_sub_s == 5'd1);
    sel_mod_s    = (sel_sub_s == 5'd1) || (sel_sub_s == 5'd3);
    mag_a_s      = mag_f(sel_a_s, sel_signed_s);
    mag_b_s      = mag_f(sel_b_s, sel_signed_s);
    bypass_s     = (sel_b_s == '0) || (mag_a_s < mag_b_s);
    if (sel_mod_s) begin
      bypass_res_s = sel_a_s;
    end else begin
      bypass_res_s = '0;
    end
  end

  // Requests are only taken in IDLE, never while reset or flush is active.
  assign accept_s       = rstn_i && !flush_i && (state_q == ST_IDLE) && grant_any_s;
  assign bus.req0_ready = accept_s && !grant_id_s;
  assign bus.req1_ready = accept_s && grant_id_s;

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_dout   = resp_dout_q;
  assign bus.div_type    = div_type_q;
  assign bus.div_subtype = div_subtype_q;
  assign bus.div_din1    = div_din1_q;
  assign bus.div_din2    = div_din2_q;
  assign bus.div_stall   = div_stall_q;
  assign bus.div_flush   = div_flush_q;

  // Control FSM, operand latches and every registered output.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      rr_q          <= 1'b0;
      id_q          <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_dout_q   <= '0;
      div_type_q    <= 4'd0;
      div_subtype_q <= 5'd0;
      div_din1_q    <= '0;
      div_din2_q    <= '0;
      div_stall_q   <= 1'b0;
      div_flush_q   <= 1'b0;
    end else if (flush_i) begin
      // Flush beats every transition, including a response handshake in progress.
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      div_type_q   <= 4'd0;
      div_stall_q  <= 1'b0;
      div_flush_q  <= (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    end else begin
      div_flush_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            rr_q <= ~grant_id_s;
            id_q <= grant_id_s;
            if (bypass_s) begin
              resp_valid_q <= 1'b1;
              resp_id_q    <= grant_id_s;
              resp_dout_q  <= bypass_res_s;
              state_q      <= ST_RESP;
            end else begin
              div_type_q    <= TDIV;
              div_subtype_q <= sel_sub_s;
              div_din1_q    <= sel_a_s;
              div_din2_q    <= sel_b_s;
              div_stall_q   <= 1'b0;
              state_q       <= ST_ISSUE;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          div_type_q  <= 4'd0;
          div_stall_q <= 1'b1;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!bus.div_busy) begin
            resp_dout_q  <= bus.div_dout;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            // Releasing stall in the first RESP cycle drains the divider to idle.
            div_stall_q  <= 1'b0;
            state_q      <= ST_RESP;
          end else begin
            div_stall_q <= 1'b1;
            state_q     <= ST_WAIT;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            state_q <= ST_RESP;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          div_type_q   <= 4'd0;
          div_stall_q  <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: table-driven self-checking bench for div_arbiter, with a
// fixed-latency behavioural divider and hand-written flush/reset/fairness sequences.
module tb_div_arbiter;
  localparam int LAT = 3;

  logic clk;
  logic rstn;
  logic flush;

  div_arbiter_if #(.WIDTH(32)) bus ();

  div_arbiter #(.WIDTH(32), .TDIV(4'd2)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .flush_i(flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural divider: result after LAT busy cycles, cleared by reset/flush.
  function automatic logic [31:0] div_model(input logic [4:0] sub, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    if (b == 32'd0) begin
      r = 32'd0;
    end else begin
      case (sub)
        5'd0: r = (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'($signed(a) / $signed(b));
        5'd1: r = (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'($signed(a) % $signed(b));
        5'd3: r = a % b;
        default: r = a / b;
      endcase
    end
    return r;
  endfunction

  logic [3:0]  cnt_r;
  logic [31:0] res_r;
  always @(posedge clk) begin
    if (!rstn || bus.div_flush) begin
      cnt_r <= 4'd0;
      res_r <= 32'd0;
    end else if (bus.div_type == 4'd2) begin
      cnt_r <= 4'(LAT);
      res_r <= div_model(bus.div_subtype, bus.div_din1, bus.div_din2);
    end else if (cnt_r != 4'd0) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end
  assign bus.div_busy = (cnt_r != 4'd0);
  assign bus.div_dout = res_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_req(input logic sel, input logic v, input logic [4:0] sub,
                         input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      bus.req1_valid = v; bus.req1_subtype = sub; bus.req1_din1 = a; bus.req1_din2 = b;
    end else begin
      bus.req0_valid = v; bus.req0_subtype = sub; bus.req0_din1 = a; bus.req0_din2 = b;
    end
  endtask

  typedef struct {
    logic        sel;
    logic [4:0]  sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        byp;
    int          hold;
  } vec_t;

  vec_t vecs[12];

  // One full operation: accept, wait for the response, check it, optional backpressure, release.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    logic seen_issue;
    logic seen_stall;
    logic [4:0] exp_sub;
    exp_sub = (v.sub > 5'd3) ? 5'd2 : v.sub;
    @(negedge clk);
    set_req(v.sel, 1'b1, v.sub, v.a, v.b);
    #1;
    chk({tag, "_ready"}, 32'(v.sel ? bus.req1_ready : bus.req0_ready), 32'd1);
    @(negedge clk);
    set_req(v.sel, 1'b0, v.sub, v.a, v.b);
    cyc = 1;
    seen_issue = 1'b0;
    seen_stall = 1'b0;
    while (!bus.resp_valid && cyc < 40) begin
      if (bus.div_type == 4'd2) begin
        seen_issue = 1'b1;
        chk({tag, "_din1"}, bus.div_din1, v.a);
        chk({tag, "_din2"}, bus.div_din2, v.b);
        chk({tag, "_sub"}, 32'(bus.div_subtype), 32'(exp_sub));
      end
      if (bus.div_stall) seen_stall = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_id"}, 32'(bus.resp_id), 32'(v.sel));
    chk({tag, "_dout"}, bus.resp_dout, v.exp);
    chk({tag, "_issued"}, 32'(seen_issue), 32'(!v.byp));
    chk({tag, "_latency"}, 32'(cyc), v.byp ? 32'd1 : 32'(LAT + 3));
    if (!v.byp) chk({tag, "_drain"}, 32'({seen_stall, bus.div_stall}), 32'd2);
    if (v.hold > 0) begin
      set_req(!v.sel, 1'b1, 5'd2, 32'd9, 32'd2);
      for (int h = 0; h < v.hold; h++) begin
        #1;
        chk({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "_hold_dout"}, bus.resp_dout, v.exp);
        chk({tag, "_hold_noacc"}, 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        @(negedge clk);
      end
      set_req(!v.sel, 1'b0, 5'd2, 32'd9, 32'd2);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({tag, "_released"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    int grants;
    int resps;
    int cyc;
    int nflush;
    logic seen_valid;

    //        sel   sub    a              b              exp            byp   hold
    vecs[0]  = '{1'b0, 5'd0, 32'd7,         32'd2,         32'd3,         1'b0, 0};
    vecs[1]  = '{1'b1, 5'd0, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0, 0};
    vecs[2]  = '{1'b1, 5'd1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1'b0, 0};
    vecs[3]  = '{1'b0, 5'd3, 32'd5,         32'd0,         32'd5,         1'b1, 0};
    vecs[4]  = '{1'b0, 5'd2, 32'd3,         32'd9,         32'd0,         1'b1, 0};
    vecs[5]  = '{1'b1, 5'd1, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFFD,  1'b1, 0};
    vecs[6]  = '{1'b0, 5'd0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0, 0};
    vecs[7]  = '{1'b1, 5'd7, 32'hFFFFFFFF,  32'd2,         32'h7FFFFFFF,  1'b0, 0};
    vecs[8]  = '{1'b0, 5'd0, 32'd5,         32'hFFFFFFFB,  32'hFFFFFFFF,  1'b0, 0};
    vecs[9]  = '{1'b1, 5'd2, 32'd1000,      32'd10,        32'd100,       1'b0, 3};
    vecs[10] = '{1'b0, 5'd0, 32'hFFFFFFF0,  32'd3,         32'hFFFFFFFB,  1'b0, 0};
    vecs[11] = '{1'b1, 5'd0, 32'd2,         32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0, 0};

    rstn = 1'b0;
    flush = 1'b0;
    bus.resp_ready = 1'b0;
    set_req(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({bus.resp_valid, bus.resp_id, bus.div_stall, bus.div_flush,
                              bus.div_type, bus.req0_ready, bus.req1_ready}), 32'd0);
    chk("reset_dout", bus.resp_dout, 32'd0);
    rstn = 1'b1;

    // Fairness: both requesters continuously valid, consumer always ready.
    @(negedge clk);
    set_req(1'b0, 1'b1, 5'd2, 32'd10, 32'd3);
    set_req(1'b1, 1'b1, 5'd2, 32'd20, 32'd3);
    bus.resp_ready = 1'b1;
    grants = 0;
    resps = 0;
    cyc = 0;
    while (resps < 4 && cyc < 300) begin
      #1;
      if (grants < 4 && (bus.req0_ready || bus.req1_ready)) begin
        chk("fair_grant", 32'(bus.req1_ready), 32'(grants % 2));
        grants++;
      end
      if (bus.resp_valid) begin
        chk("fair_id", 32'(bus.resp_id), 32'(resps % 2));
        chk("fair_dout", bus.resp_dout, bus.resp_id ? 32'd6 : 32'd3);
        resps++;
      end
      @(negedge clk);
      cyc++;
      if (grants == 4) begin
        set_req(1'b0, 1'b0, 5'd2, 32'd10, 32'd3);
        set_req(1'b1, 1'b0, 5'd2, 32'd20, 32'd3);
      end
    end
    chk("fair_done", 32'(resps), 32'd4);
    bus.resp_ready = 1'b0;
    set_req(1'b0, 1'b0, 5'd2, 32'd10, 32'd3);
    set_req(1'b1, 1'b0, 5'd2, 32'd20, 32'd3);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Flush together with resp_ready in RESP: response dropped, no divider flush.
    @(negedge clk);
    set_req(1'b0, 1'b1, 5'd2, 32'd3, 32'd9);
    @(negedge clk);
    set_req(1'b0, 1'b0, 5'd2, 32'd3, 32'd9);
    chk("rflush_valid_before", 32'(bus.resp_valid), 32'd1);
    flush = 1'b1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.resp_ready = 1'b0;
    chk("rflush_valid_after", 32'(bus.resp_valid), 32'd0);
    chk("rflush_divflush", 32'(bus.div_flush), 32'd0);

    // Flush during WAIT, with a competing request presented in the flush cycle.
    @(negedge clk);
    set_req(1'b0, 1'b1, 5'd2, 32'd50, 32'd5);
    @(negedge clk);
    set_req(1'b0, 1'b0, 5'd2, 32'd50, 32'd5);
    @(negedge clk);
    chk("wflush_in_wait", 32'(bus.div_stall), 32'd1);
    flush = 1'b1;
    set_req(1'b1, 1'b1, 5'd2, 32'd9, 32'd3);
    #1;
    chk("wflush_noaccept", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    set_req(1'b1, 1'b0, 5'd2, 32'd9, 32'd3);
    chk("wflush_pulse", 32'(bus.div_flush), 32'd1);
    chk("wflush_type", 32'(bus.div_type), 32'd0);
    chk("wflush_valid", 32'(bus.resp_valid), 32'd0);
    nflush = 0;
    seen_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.div_flush) nflush++;
      if (bus.resp_valid) seen_valid = 1'b1;
    end
    chk("wflush_single_pulse", 32'(nflush), 32'd0);
    chk("wflush_no_result", 32'(seen_valid), 32'd0);
    run_vec('{1'b0, 5'd2, 32'd100, 32'd7, 32'd14, 1'b0, 0}, "post_flush");

    // Reset in the middle of WAIT clears every output in the next cycle.
    @(negedge clk);
    set_req(1'b1, 1'b1, 5'd2, 32'd100, 32'd7);
    @(negedge clk);
    set_req(1'b1, 1'b0, 5'd2, 32'd100, 32'd7);
    @(negedge clk);
    chk("mrst_in_wait", 32'(bus.div_stall), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("mrst_ctrl", 32'({bus.resp_valid, bus.resp_id, bus.div_stall, bus.div_flush,
                          bus.div_type, bus.div_subtype}), 32'd0);
    chk("mrst_dout", bus.resp_dout, 32'd0);
    chk("mrst_din1", bus.div_din1, 32'd0);
    chk("mrst_din2", bus.div_din2, 32'd0);
    run_vec('{1'b0, 5'd1, 32'h80000000, 32'd3, 32'hFFFFFFFE, 1'b0, 0}, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one iterative divider between two issue pipes (req0 = pipe A, req1 = pipe B).
- Arbitrates round-robin, latches operands and sequences the divider's start/stall/drain protocol.
- Returns each result on a single valid/ready response channel tagged with the requester id.
- Resolves divide-by-zero and small-dividend cases locally, without using the divider.

Parameters:
- WIDTH, 32, operand and result width.
- TDIV, 2, type code driven to the divider to start an operation.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- flush  in  1  pipeline flush; kills any in-flight operation.
- req0_valid, req1_valid  in  1  request valid.
- req0_ready, req1_ready  out  1  request accepted this cycle.
- req0_subtype, req1_subtype  in  5  0=DIVW, 1=MODW, 2=DIVWU, 3=MODWU.
- req0_din1, req1_din1  in  WIDTH  dividend.
- req0_din2, req1_din2  in  WIDTH  divisor.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  1  requester index of the result.
- resp_dout  out  WIDTH  result.
- div_type  out  4  TDIV during the issue cycle, 0 otherwise.
- div_subtype  out  5  latched subtype, held from issue until capture.
- div_din1, div_din2  out  WIDTH  latched operands.
- div_stall  out  1  hold for the divider's output state.
- div_flush  out  1  divider flush.
- div_busy  in  1  divider busy (combinational from the divider).
- div_dout  in  WIDTH  divider result.

Behaviour:
- Reset (rstn low at clk edge):
  - state=IDLE, rr pointer=0.
  - All outputs 0: ready, resp_valid, resp_id, resp_dout, div_type, div_subtype, div_din*, div_stall, div_flush.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - ready is combinational: asserted only for the arbitration winner.
  - Winner is the sole valid requester; if both are valid, the one selected by the rr pointer.
  - On accept: latch id, subtype, din1, din2; toggle rr pointer to favour the other requester next.
  - Bypass check on latched operands. Magnitudes |a|, |b| are two's-complement negations for DIVW/MODW with a set MSB, raw values otherwise.
    - din2==0: result = 0 for DIV, din1 for MOD.
    - |a|<|b| (unsigned): result = 0 for DIV, din1 for MOD.
    - Bypass goes directly to RESP; resp_valid asserts the cycle after accept.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): div_type=TDIV, div_stall=0, latched operands and subtype driven; go to WAIT.
- WAIT:
  - div_type=0, div_stall=1, subtype and operands still driven.
  - Sample div_busy each cycle.
  - When div_busy==0: capture div_dout into resp_dout, go to RESP.
- RESP:
  - resp_valid=1, resp_id and resp_dout held stable until resp_ready.
  - div_stall=0 in the first RESP cycle after a divider operation (drain pulse). This releases the divider to its idle state.
  - On resp_valid&&resp_ready: go to IDLE, no accept in the same cycle.
- ready is 0 in ISSUE, WAIT and RESP; a single outstanding operation at a time.
- Latency:
  - Bypass: accept→resp_valid = 1 cycle.
  - Divider path: accept, ISSUE, WAIT (divider cycles + 1), capture; resp_valid is asserted the cycle after busy falls.
- Fairness: with both requesters continuously valid, grants alternate strictly.
- flush (has priority over all transitions):
  - Next state IDLE, resp_valid dropped, no result delivered.
  - div_flush=1 for exactly one cycle when the state was ISSUE or WAIT; div_type=0 in that cycle.
  - Requests presented during the flush cycle are not accepted.
- Simultaneous resp_ready and flush: flush wins; the transfer does not count.
- Subtypes other than 0-3 are treated as DIVWU.
- Signed results (DIVW/MODW, produced by the divider):
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF returns 0x80000000.

Test Plan:
- req0 DIVW din1=7, din2=2 -> one ISSUE cycle with div_type=2; resp_id=0, resp_dout=3; drain pulse observed; back to IDLE.
- req1 DIVW din1=0xFFFFFFF9 (-7), din2=2 -> resp_dout=0xFFFFFFFD. Same operands with MODW -> 0xFFFFFFFF.
- req0 MODWU din1=5, din2=0 -> bypass, resp_dout=5 one cycle after accept. DIVWU din1=3, din2=9 -> resp_dout=0, div_type never asserted.
- Both requesters valid continuously for 4 operations -> grants 0,1,0,1. resp_ready held low for 3 cycles -> resp_dout stable, no new accept.
- flush during WAIT -> div_flush pulses for 1 cycle, no resp_valid. A following DIVWU 100/7 -> resp_dout=14.
- rstn low mid-WAIT -> all outputs 0 the next cycle. A subsequent MODW 0x80000000 % 3 -> resp_dout=0xFFFFFFFE.
